// File: rtl/eth_tx_sched_pkg.sv
// eth_tx_sched_pkg
// Shared definitions for the RGMII transmit scheduler: FSM state encoding,
// peripheral register map, kick value and the byte-to-word conversion.
package eth_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LEN,
        ST_DATA,
        ST_KICK,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_e;

    localparam logic [31:0] TX_BASE  = 32'h0000_1000;
    localparam logic [31:0] REG_LEN  = 32'h0000_0810;
    localparam logic [31:0] REG_LAST = 32'h0000_0828;
    localparam logic [63:0] KICK_VAL = 64'd8;

    // WAIT_BUSY lasts at most 16 cycles: timer counts 15 down to 0.
    localparam logic [3:0]  BUSY_TMR_LOAD = 4'd15;

    // Stall watchdog terminal count (optional build only).
    localparam logic [19:0] TIMEOUT_MAX = 20'hF_FFFF;

    // ceil(len / 8); 17-bit sum so len=16'hFFFF cannot wrap.
    function automatic logic [10:0] words_from_bytes(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd7;
        return sum[13:3];
    endfunction

endpackage

// File: rtl/eth_rr_arb.sv
// eth_rr_arb
// Round-robin arbiter. Grant is purely combinational: the first asserted
// request at or after the pointer. The pointer only moves when upd_i is
// pulsed, and then goes to the slot after upd_owner_i.
// Ports:
//   clk_i, rst_i   clock, async active-high reset (pointer -> 0)
//   req_i          per-requester request
//   upd_i          advance pointer past upd_owner_i this cycle
//   upd_owner_i    requester that just finished
//   gnt_valid_o    some request is set
//   gnt_idx_o      selected requester
module eth_rr_arb
    import eth_tx_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic                     upd_i,
    input  logic [$clog2(NREQ)-1:0]  upd_owner_i,
    output logic                     gnt_valid_o,
    output logic [$clog2(NREQ)-1:0]  gnt_idx_o
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            if (upd_owner_i == IW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = upd_owner_i + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Scan from farthest to nearest so the slot closest to the pointer wins.
    always_comb begin
        int idx;
        idx         = 0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched
// Transmit scheduler for the RGMII peripheral. Picks a frame descriptor
// round-robin, validates its length, then writes the length register, the
// payload words into the TX buffer and the kick register, and waits for the
// peripheral to go busy and back to idle before taking the next frame.
// Build option: define ETH_TX_SCHED_TIMEOUT_EN to add a 20-bit stall watchdog
// in DATA and WAIT_DONE that aborts the frame with an err_o pulse.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   desc_valid_i/len  per-requester frame request and byte length
//   desc_ready_o      one-cycle pulse when a descriptor is accepted/rejected
//   data_valid_i/data per-requester payload word (little-endian)
//   data_ready_o      payload word consumed
//   err_o             one-cycle pulse on a rejected (or timed-out) frame
//   bus_*             single-beat write bus to the peripheral
//   tx_busy_i         peripheral is transmitting
//   busy_o            FSM not in IDLE
//   owner_o           currently granted requester
//
// state        | meaning
// -------------+--------------------------------------------------
// ST_IDLE      | waiting for a descriptor
// ST_CHECK     | length validation, descriptor handshake
// ST_LEN       | writing the length register
// ST_DATA      | streaming payload words into the TX buffer
// ST_KICK      | writing the kick register
// ST_WAIT_BUSY | waiting (max 16 cycles) for the peripheral to go busy
// ST_WAIT_DONE | waiting for the peripheral to return to idle
module eth_tx_sched #(
    parameter int            NREQ      = 2,
    parameter int            AW        = 32,
    parameter int            DW        = 64,
    parameter int            MAX_BYTES = 2048,
    parameter logic [AW-1:0] TX_BASE   = AW'(eth_tx_sched_pkg::TX_BASE),
    parameter logic [AW-1:0] REG_LEN   = AW'(eth_tx_sched_pkg::REG_LEN),
    parameter logic [AW-1:0] REG_LAST  = AW'(eth_tx_sched_pkg::REG_LAST)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          desc_valid_i,
    input  logic [NREQ*16-1:0]       desc_len_i,
    output logic [NREQ-1:0]          desc_ready_o,
    input  logic [NREQ-1:0]          data_valid_i,
    input  logic [NREQ*DW-1:0]       data_i,
    output logic [NREQ-1:0]          data_ready_o,
    output logic [NREQ-1:0]          err_o,
    output logic                     bus_req_o,
    output logic [AW-1:0]            bus_addr_o,
    output logic [DW-1:0]            bus_wdata_o,
    output logic [7:0]               bus_be_o,
    input  logic                     bus_gnt_i,
    input  logic                     tx_busy_i,
    output logic                     busy_o,
    output logic [$clog2(NREQ)-1:0]  owner_o
);

    import eth_tx_sched_pkg::*;

    localparam int IW = $clog2(NREQ);

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [15:0]   len_q,   len_d;
    logic [10:0]   words_q, words_d;
    logic [10:0]   idx_q,   idx_d;
    logic [3:0]    tmr_q,   tmr_d;

    logic          arb_valid;
    logic [IW-1:0] arb_idx;
    logic          rr_upd;
    logic          len_bad;
    logic          word_done;

`ifdef ETH_TX_SCHED_TIMEOUT_EN
    logic [19:0]   to_q, to_d;
`endif

    eth_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (desc_valid_i),
        .upd_i       (rr_upd),
        .upd_owner_i (owner_q),
        .gnt_valid_o (arb_valid),
        .gnt_idx_o   (arb_idx)
    );

    assign len_bad   = (len_q == 16'd0) || (int'(len_q) > MAX_BYTES);
    // A payload word moves only when it is both offered and granted.
    assign word_done = bus_gnt_i && data_valid_i[owner_q];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        len_d        = len_q;
        words_d      = words_q;
        idx_d        = idx_q;
        tmr_d        = tmr_q;
        rr_upd       = 1'b0;
        bus_req_o    = 1'b0;
        bus_addr_o   = '0;
        bus_wdata_o  = '0;
        bus_be_o     = 8'h00;
        desc_ready_o = '0;
        data_ready_o = '0;
        err_o        = '0;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
        to_d         = to_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_idx;
                    len_d   = desc_len_i[arb_idx*16 +: 16];
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                desc_ready_o[owner_q] = 1'b1;
                if (len_bad) begin
                    err_o[owner_q] = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    words_d = words_from_bytes(len_q);
                    idx_d   = '0;
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                bus_req_o   = 1'b1;
                bus_addr_o  = REG_LEN;
                bus_wdata_o = DW'(len_q);
                bus_be_o    = 8'h0F;
                if (bus_gnt_i) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                bus_req_o   = data_valid_i[owner_q];
                bus_addr_o  = TX_BASE + AW'({idx_q, 3'b000});
                bus_wdata_o = data_i[owner_q*DW +: DW];
                bus_be_o    = 8'hFF;
                if (word_done) begin
                    data_ready_o[owner_q] = 1'b1;
                    idx_d                 = idx_q + 11'd1;
                    if (idx_q == words_q - 11'd1) begin
                        state_d = ST_KICK;
                    end
                end
            end

            ST_KICK: begin
                bus_req_o   = 1'b1;
                bus_addr_o  = REG_LAST;
                bus_wdata_o = KICK_VAL;
                bus_be_o    = 8'h0F;
                if (bus_gnt_i) begin
                    tmr_d   = BUSY_TMR_LOAD;
                    state_d = ST_WAIT_BUSY;
                end
            end

            ST_WAIT_BUSY: begin
                // A peripheral that never reports busy must not hang us.
                if (tx_busy_i || (tmr_q == 4'd0)) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    rr_upd  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef ETH_TX_SCHED_TIMEOUT_EN
        if ((state_q == ST_DATA) || (state_q == ST_WAIT_DONE)) begin
            if ((state_d != state_q) || ((state_q == ST_DATA) && word_done)) begin
                to_d = '0;
            end else if (to_q == TIMEOUT_MAX) begin
                err_o[owner_q] = 1'b1;
                bus_req_o      = 1'b0;
                rr_upd         = 1'b1;
                to_d           = '0;
                state_d        = ST_IDLE;
            end else begin
                to_d = to_q + 20'd1;
            end
        end else begin
            to_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            len_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign owner_o = owner_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
module tb_eth_tx_sched;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   desc_valid_i;
    logic [31:0]  desc_len_i;
    logic [1:0]   desc_ready_o;
    logic [1:0]   data_valid_i;
    logic [127:0] data_i;
    logic [1:0]   data_ready_o;
    logic [1:0]   err_o;
    logic         bus_req_o;
    logic [31:0]  bus_addr_o;
    logic [63:0]  bus_wdata_o;
    logic [7:0]   bus_be_o;
    logic         bus_gnt_i;
    logic         tx_busy_i;
    logic         busy_o;
    logic [0:0]   owner_o;

    always #5 clk_i = ~clk_i;

    eth_tx_sched dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .desc_valid_i (desc_valid_i),
        .desc_len_i   (desc_len_i),
        .desc_ready_o (desc_ready_o),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_be_o     (bus_be_o),
        .bus_gnt_i    (bus_gnt_i),
        .tx_busy_i    (tx_busy_i),
        .busy_o       (busy_o),
        .owner_o      (owner_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } wr_t;

    typedef struct {
        int   r;
        logic err;
    } ev_t;

    typedef struct {
        logic [1:0] vm;
        int         l0;
        int         l1;
        int         first;
        logic [1:0] err;
        int         w0;
        int         w1;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc_n = 0;
    wr_t         exp_q[$];
    ev_t         ev_q[$];
    logic [63:0] src0[$];
    logic [63:0] src1[$];
    int          ptr_m = 0;
    bit          stall_en = 0;
    bit          bubble_en = 0;
    bit          busy_en = 1;
    int          busy_wait = 0;
    int          busy_len = 0;
    int          dr_cnt[2];
    int          err_cnt[2];
    int          first_owner;
    logic        prev_req = 0, prev_gnt = 0, prev_busy = 0;
    logic [31:0] prev_addr;
    logic [63:0] prev_data;
    logic [7:0]  prev_be;
    int          kick_cyc = 0, idle_cyc = 0;
    vec_t        tbl[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int words_of(input int len);
        return (len + 7) / 8;
    endfunction

    // Reference: frames are served starting at the round-robin pointer; a
    // rejected frame produces no writes and does not move the pointer, a good
    // frame moves the pointer past its owner.
    task automatic start_frames(input logic [1:0] vm, input int l0, input int l1);
        int order[2];
        int lens[2];
        int r;
        logic [63:0] w;
        logic bad_len;
        lens[0] = l0;
        lens[1] = l1;
        order[0] = ptr_m;
        order[1] = 1 - ptr_m;
        first_owner = -1;
        for (int k = 0; k < 2; k++) begin
            r = order[k];
            if (vm[r]) begin
                bad_len = (lens[r] == 0) || (lens[r] > 2048);
                ev_q.push_back('{r, bad_len});
                if (!bad_len) begin
                    exp_q.push_back('{32'h0000_0810, 64'(lens[r]), 8'h0F});
                    for (int i = 0; i < words_of(lens[r]); i++) begin
                        w = {$urandom, $urandom};
                        if (r == 0) src0.push_back(w);
                        else        src1.push_back(w);
                        exp_q.push_back('{32'h0000_1000 + 32'(8 * i), w, 8'hFF});
                    end
                    exp_q.push_back('{32'h0000_0828, 64'h8, 8'h0F});
                    ptr_m = (r + 1) % 2;
                end
            end
        end
        desc_len_i[15:0]  = 16'(l0);
        desc_len_i[31:16] = 16'(l1);
        desc_valid_i      = vm;
    endtask

    task automatic observe();
        wr_t e;
        ev_t v;
        if (prev_req && !prev_gnt && bus_req_o) begin
            chk("hold_addr", bus_addr_o, prev_addr);
            chk("hold_data", bus_wdata_o, prev_data);
            chk("hold_be", bus_be_o, prev_be);
        end
        if (bus_req_o && bus_gnt_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write got addr=%0h expected none", bus_addr_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus_addr_o, e.addr);
                chk("wr_data", bus_wdata_o, e.data);
                chk("wr_be", bus_be_o, e.be);
            end
            if (bus_addr_o == 32'h0000_0828) begin
                kick_cyc = cyc_n;
                if (busy_en) begin
                    busy_wait = $urandom_range(0, 6);
                    busy_len  = $urandom_range(1, 5);
                end
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (data_ready_o[r]) begin
                chk("ready_needs_valid", data_valid_i[r], 1);
                dr_cnt[r]++;
                if (r == 0 && src0.size() > 0) void'(src0.pop_front());
                if (r == 1 && src1.size() > 0) void'(src1.pop_front());
            end
            if (desc_ready_o[r]) begin
                if (first_owner < 0) first_owner = r;
                if (err_o[r]) err_cnt[r]++;
                if (ev_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_desc_ready got req=%0d expected none", r);
                end else begin
                    v = ev_q.pop_front();
                    chk("desc_owner", r, v.r);
                    chk("desc_err", err_o[r], v.err);
                    chk("owner_o", owner_o, r);
                end
                desc_valid_i[r] = 1'b0;
            end else if (err_o[r]) begin
                total++;
                bad++;
                $display("FAIL err_without_ready got req=%0d expected no err", r);
            end
        end
        if (prev_busy && !busy_o) begin
            idle_cyc = cyc_n;
            if (busy_en) chk("hold_until_tx_idle", (busy_wait == 0) && (busy_len == 0), 1);
        end
        prev_req  = bus_req_o;
        prev_gnt  = bus_gnt_i;
        prev_addr = bus_addr_o;
        prev_data = bus_wdata_o;
        prev_be   = bus_be_o;
        prev_busy = busy_o;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
        data_valid_i[0] = (src0.size() > 0) && (!bubble_en || $urandom_range(0, 3) != 0);
        data_valid_i[1] = (src1.size() > 0) && (!bubble_en || $urandom_range(0, 3) != 0);
        data_i[63:0]    = (src0.size() > 0) ? src0[0] : 64'h0;
        data_i[127:64]  = (src1.size() > 0) ? src1[0] : 64'h0;
        if (!busy_en) begin
            tx_busy_i = 1'b0;
        end else if (busy_wait > 0) begin
            busy_wait--;
            tx_busy_i = 1'b0;
        end else if (busy_len > 0) begin
            busy_len--;
            tx_busy_i = 1'b1;
        end else begin
            tx_busy_i = 1'b0;
        end
        #1;
        bus_gnt_i = bus_req_o && (!stall_en || $urandom_range(0, 2) != 0);
        @(negedge clk_i);
        cyc_n++;
        observe();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && ev_q.size() == 0 && !busy_o && desc_valid_i == 2'b00)
               && n < budget) begin
            cyc();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s got pending_writes=%0d expected 0 within %0d cycles",
                     tag, exp_q.size(), budget);
        end
        repeat (3) cyc();
        chk({tag, "_src0_drained"}, src0.size(), 0);
        chk({tag, "_src1_drained"}, src1.size(), 0);
    endtask

    initial begin
        logic [1:0] vm;
        int         l0, l1, n;

        tbl[0] = '{2'b11,   16,   16, 0, 2'b00,   2, 2};
        tbl[1] = '{2'b11,   16,   16, 0, 2'b00,   2, 2};
        tbl[2] = '{2'b01,   64,    0, 0, 2'b00,   8, 0};
        tbl[3] = '{2'b01,    0,    0, 0, 2'b01,   0, 0};
        tbl[4] = '{2'b10,    0, 2049, 1, 2'b10,   0, 0};
        tbl[5] = '{2'b01,   13,    0, 0, 2'b00,   2, 0};
        tbl[6] = '{2'b10,    0, 2048, 1, 2'b00,   0, 256};
        tbl[7] = '{2'b11,    0,    8, 0, 2'b01,   0, 1};
        tbl[8] = '{2'b11,    9,    1, 0, 2'b00,   2, 1};

        rst_i        = 1'b1;
        desc_valid_i = '0;
        desc_len_i   = '0;
        data_valid_i = '0;
        data_i       = '0;
        bus_gnt_i    = 1'b0;
        tx_busy_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_desc_ready", desc_ready_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int t = 0; t < 9; t++) begin
            dr_cnt  = '{0, 0};
            err_cnt = '{0, 0};
            start_frames(tbl[t].vm, tbl[t].l0, tbl[t].l1);
            run_until_idle(2000, $sformatf("vec%0d_timeout", t));
            chk($sformatf("vec%0d_first_owner", t), first_owner, tbl[t].first);
            chk($sformatf("vec%0d_err0", t), err_cnt[0], tbl[t].err[0]);
            chk($sformatf("vec%0d_err1", t), err_cnt[1], tbl[t].err[1]);
            chk($sformatf("vec%0d_words0", t), dr_cnt[0], tbl[t].w0);
            chk($sformatf("vec%0d_words1", t), dr_cnt[1], tbl[t].w1);
        end

        stall_en  = 1;
        bubble_en = 1;
        for (int it = 0; it < 25; it++) begin
            vm = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 9))
                0:       l0 = 0;
                1:       l0 = 2049 + $urandom_range(0, 100);
                2:       l0 = 2048;
                default: l0 = $urandom_range(1, 120);
            endcase
            case ($urandom_range(0, 9))
                0:       l1 = 0;
                1:       l1 = 2049 + $urandom_range(0, 100);
                default: l1 = $urandom_range(1, 120);
            endcase
            start_frames(vm, l0, l1);
            run_until_idle(3000, "rand_timeout");
        end

        // Peripheral never reports busy: controller gives up waiting after
        // 16 cycles, then sees idle and returns.
        stall_en  = 0;
        bubble_en = 0;
        busy_en   = 0;
        start_frames(2'b01, 8, 0);
        run_until_idle(200, "nobusy_timeout");
        chk("nobusy_min_wait", (idle_cyc - kick_cyc) >= 17, 1);
        chk("nobusy_max_wait", (idle_cyc - kick_cyc) <= 19, 1);
        busy_en = 1;

        // Reset in the middle of a frame, with requester 1 owning the bus.
        dr_cnt  = '{0, 0};
        err_cnt = '{0, 0};
        start_frames(2'b10, 0, 64);
        n = 0;
        while (dr_cnt[1] < 3 && n < 200) begin
            cyc();
            n++;
        end
        chk("rst_reach_data", dr_cnt[1], 3);
        @(posedge clk_i);
        #1;
        rst_i        = 1'b1;
        bus_gnt_i    = 1'b0;
        desc_valid_i = '0;
        data_valid_i = '0;
        @(negedge clk_i);
        chk("midrst_bus_req", bus_req_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_owner", owner_o, 0);
        chk("midrst_data_ready", data_ready_o, 0);
        chk("midrst_desc_ready", desc_ready_o, 0);
        chk("midrst_err", err_o, 0);
        chk("midrst_addr", bus_addr_o, 0);
        chk("midrst_wdata", bus_wdata_o, 0);
        chk("midrst_be", bus_be_o, 0);
        exp_q.delete();
        ev_q.delete();
        src0.delete();
        src1.delete();
        busy_wait = 0;
        busy_len  = 0;
        ptr_m     = 0;
        prev_req  = 0;
        prev_busy = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        dr_cnt  = '{0, 0};
        start_frames(2'b11, 16, 16);
        run_until_idle(500, "postrst_timeout");
        chk("postrst_first_owner", first_owner, 0);
        chk("postrst_words0", dr_cnt[0], 2);
        chk("postrst_words1", dr_cnt[1], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Transmit-side controller for the RGMII Ethernet peripheral. It arbitrates frame requests from two requesters and programs the peripheral through its register/memory bus.
- For each granted frame it writes the packet-length register (0x810), then the TX buffer (0x1000 + 8·i), then the "last" register (0x828) to start transmission. It holds off the next frame until the peripheral reports TX idle.
- Sits between CPU/DMA frame sources and the peripheral's slave bus.

Parameters:
- NREQ, 2, number of requesters (round-robin).
- AW, 32, bus address width.
- DW, 64, bus data width (fixed 64).
- MAX_BYTES, 2048, largest frame accepted (TX buffer size).
- TX_BASE, 32'h0000_1000, TX buffer base address.
- REG_LEN, 32'h0000_0810, length register address.
- REG_LAST, 32'h0000_0828, kick register address.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- desc_valid_i  in  NREQ  per-requester frame request.
- desc_len_i  in  NREQ×16  frame length in bytes.
- desc_ready_o  out  NREQ  descriptor accepted or rejected (one-cycle pulse).
- data_valid_i  in  NREQ  payload word valid.
- data_i  in  NREQ×64  payload word, little-endian byte order.
- data_ready_o  out  NREQ  payload word consumed.
- err_o  out  NREQ  one-cycle pulse on rejected descriptor.
- bus_req_o  out  1  bus write request.
- bus_addr_o  out  AW  bus address.
- bus_wdata_o  out  64  bus write data.
- bus_be_o  out  8  byte enables.
- bus_gnt_i  in  1  bus accepted the write.
- tx_busy_i  in  1  peripheral transmitting.
- busy_o  out  1  controller not in IDLE.
- owner_o  out  $clog2(NREQ)  currently granted requester.

Behaviour:
- Reset values: all outputs 0. Round-robin pointer = 0. State = IDLE.
- Reset asserted mid-frame aborts immediately. No further bus writes are issued. The requester must restart the frame.
- States:
  - IDLE: if any desc_valid_i, pick the first set bit starting at rr_ptr; latch owner and length. → CHECK.
  - CHECK: if len==0 or len>MAX_BYTES, pulse desc_ready_o and err_o for owner → IDLE. Otherwise pulse desc_ready_o, set words=ceil(len/8) (11-bit), i=0. → LEN.
  - LEN: bus write addr=REG_LEN, wdata={48'b0,len}, be=8'h0F. On gnt → DATA.
  - DATA: data_ready_o[owner] = bus_gnt_i (word is consumed on gnt).
    - bus_req_o = data_valid_i[owner]; addr=TX_BASE+8·i, be=8'hFF.
    - On gnt: i++. If i==words-1 → KICK.
    - Valid low inserts bubbles with no timeout.
  - KICK: bus write addr=REG_LAST, wdata=64'h8, be=8'h0F. On gnt → WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy_i==1, max 16 cycles, then → WAIT_DONE regardless.
  - WAIT_DONE: wait for tx_busy_i==0. Then rr_ptr=owner+1 mod NREQ → IDLE.
- Bus rule: addr/wdata/be are stable while req is high and not granted; req drops the cycle after gnt unless a new write follows. Latency from gnt to next req: at most 1 cycle. Back-to-back DATA writes proceed at 1 word/cycle under continuous gnt and valid.
- Partial final word is written with full be=8'hFF; the peripheral uses the length register.
- Simultaneous requests: round-robin; a requester is not granted twice while the other waits.
- Deasserting desc_valid_i after grant has no effect.
- busy_o is high in every state other than IDLE.

Optional Feature:
- ETH_TX_SCHED_TIMEOUT_EN.
- Defined: a 20-bit counter runs in DATA and WAIT_DONE, reset on any progress (gnt or state change). At 2^20−1 the block pulses err_o[owner], drops bus_req_o, and returns to IDLE.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package eth_tx_sched_pkg: state enum, register address constants (REG_LEN, REG_LAST, TX_BASE, KICK_VAL=8), and the words-from-bytes function.
- Sub-module eth_rr_arb: NREQ round-robin, combinational grant plus pointer-update input.

Test Plan:
- Req0 len=64 with 8 words and continuous gnt → writes 0x810=0x40, 0x1000..0x1038 data in order, 0x828=0x8; tx_busy pulse → IDLE, busy_o=0.
- Req0 and req1 valid in the same cycle with len=16 each → req0 served first, then req1. Owner sequence is 0,1, then 0 on the next simultaneous request.
- len=0 and len=2049 → err_o pulse, no bus activity, desc_ready_o pulse.
- len=13 → 2 data writes at 0x1000 and 0x1008, length register = 0xD.
- Random gnt stalls and data_valid bubbles → addr/data held stable under stall, no word lost or duplicated.
- rst_i asserted during DATA (i=3) → all outputs 0 the next cycle; a fresh frame after reset starts with the LEN write.
